// File: rtl/regfile_param.sv
// regfile_param: two-read/one-write register file with a DEPTH-cycle bulk-clear sweep; define REGFILE_BYPASS_EN for write-to-read forwarding.
// Latency: reads are combinational; a write is visible the cycle after its edge; a clear sweep takes DEPTH cycles.
// Backpressure: none; Busy is high during a sweep, while writes and clear requests are ignored and both reads return 0.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Wr_en,
    input  logic [AW-1:0]   Wr_idx,
    input  logic [XLEN-1:0] Data_in,
    input  logic [AW-1:0]   R1_idx,
    input  logic [AW-1:0]   R2_idx,
    input  logic            Clr_req,
    output logic [XLEN-1:0] REG_1,
    output logic [XLEN-1:0] REG_2,
    output logic            Busy
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    // Depth widened by one bit so indices up to 2**AW-1 compare cleanly.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [DEPTH];

    logic wr_legal;
    logic wr_fire;

    // An index is writable if it exists and is not the hardwired zero entry.
    assign wr_legal = ({1'b0, Wr_idx} < DEPTH_W) && !(ZERO_REG && (Wr_idx == '0));
    // A clear request in the same cycle takes priority over the write.
    assign wr_fire  = (state == IDLE) && Wr_en && !Clr_req && wr_legal;

    // Read one port: zero during a sweep, for missing entries and for entry 0 when hardwired.
    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if ((state == IDLE) && ({1'b0, idx} < DEPTH_W) && !(ZERO_REG && (idx == '0))) begin
            val = mem[idx];
`ifdef REGFILE_BYPASS_EN
            if (Wr_en && wr_legal && (Wr_idx == idx)) begin
                val = Data_in;
            end
`endif
        end
        return val;
    endfunction

    // Sweep control: reset or a clear request starts a sweep from entry 0; Busy mirrors the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            Busy  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (Clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    Busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage: the sweep zeroes one entry per cycle, otherwise accept legal writes; no reset on the array.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_fire) begin
                mem[Wr_idx] <= Data_in;
            end
        end
    end

    // Both read ports are purely combinational.
    always_comb begin
        REG_1 = rd_port(R1_idx);
        REG_2 = rd_port(R2_idx);
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives three regfile_param builds (32/zero-reg, 32/no-zero-reg, 24/zero-reg) from one stimulus stream.
// A per-instance array model predicts Busy and both reads every cycle; directed steps add literal expectations.
// Inputs change 1 ns after the rising edge, the model compare runs on the falling edge.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, clr;
    logic [4:0]  widx, r1, r2;
    logic [31:0] din;

    logic [2:0][31:0] q1;
    logic [2:0][31:0] q2;
    logic [2:0]       bsy;

    int errors = 0;
    int checks = 0;

    regfile_param #(.XLEN(32), .DEPTH(32), .ZERO_REG(1'b1)) u_d32 (
        .clk(clk), .rst(rst), .Wr_en(we), .Wr_idx(widx), .Data_in(din),
        .R1_idx(r1), .R2_idx(r2), .Clr_req(clr),
        .REG_1(q1[0]), .REG_2(q2[0]), .Busy(bsy[0])
    );

    regfile_param #(.XLEN(32), .DEPTH(32), .ZERO_REG(1'b0)) u_z0 (
        .clk(clk), .rst(rst), .Wr_en(we), .Wr_idx(widx), .Data_in(din),
        .R1_idx(r1), .R2_idx(r2), .Clr_req(clr),
        .REG_1(q1[1]), .REG_2(q2[1]), .Busy(bsy[1])
    );

    regfile_param #(.XLEN(32), .DEPTH(24), .ZERO_REG(1'b1)) u_d24 (
        .clk(clk), .rst(rst), .Wr_en(we), .Wr_idx(widx), .Data_in(din),
        .R1_idx(r1), .R2_idx(r2), .Clr_req(clr),
        .REG_1(q1[2]), .REG_2(q2[2]), .Busy(bsy[2])
    );

    // ---------------- model ----------------
    int          dep [3] = '{32, 32, 24};
    bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mm  [3][32];
    int          left [3];
    bit          m_valid = 1'b0;

    function automatic bit legal(input int k, input logic [4:0] i);
        return (int'(i) < dep[k]) && !(zr[k] && (i == 5'd0));
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] i);
        if (left[k] > 0 || !legal(k, i)) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && legal(k, widx) && (widx == i)) return din;
`endif
        return mm[k][i];
    endfunction

    // Model update: a sweep lasts dep edges and leaves every entry zero.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                left[k] <= dep[k];
                for (int e = 0; e < 32; e++) mm[k][e] <= 32'd0;
            end else if (left[k] > 0) begin
                left[k] <= left[k] - 1;
            end else if (clr) begin
                left[k] <= dep[k];
                for (int e = 0; e < 32; e++) mm[k][e] <= 32'd0;
            end else if (we && legal(k, widx)) begin
                mm[k][widx] <= din;
            end
        end
        if (rst) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Continuous compare of all three instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("m%0d_busy", k), {31'd0, bsy[k]}, {31'd0, (left[k] > 0)});
                chk($sformatf("m%0d_reg1", k), q1[k], exp_rd(k, r1));
                chk($sformatf("m%0d_reg2", k), q2[k], exp_rd(k, r2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int          fall [3];
        logic [31:0] coll_exp;

        rst = 1'b1; we = 1'b0; clr = 1'b0; widx = '0; din = '0; r1 = '0; r2 = '0;

        // Reset sweep: rst high for two edges, then count edges until Busy falls.
        tick();
        #2;
        chk("rst_busy_d32", {31'd0, bsy[0]}, 32'd1);
        chk("rst_busy_d24", {31'd0, bsy[2]}, 32'd1);
        chk("rst_reg1_zero", q1[0], 32'd0);
        tick();
        rst = 1'b0;
        fall = '{0, 0, 0};
        for (int n = 1; n <= 40; n++) begin
            tick();
            for (int k = 0; k < 3; k++) if (fall[k] == 0 && bsy[k] == 1'b0) fall[k] = n;
        end
        chk("rst_fall_d32", fall[0], 32'd32);
        chk("rst_fall_z0",  fall[1], 32'd32);
        chk("rst_fall_d24", fall[2], 32'd24);

        // Every entry reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i); r2 = 5'(31 - i);
            #2;
            chk("post_rst_r1", q1[0], 32'd0);
            chk("post_rst_r2", q2[1], 32'd0);
            tick();
        end

        // Basic write/read.
        we = 1'b1; widx = 5'd1; din = 32'hDEAD_BEEF;
        tick();
        widx = 5'd2; din = 32'h1234_5678;
        tick();
        we = 1'b0; r1 = 5'd1; r2 = 5'd2;
        #2;
        chk("wr_rd_r1", q1[0], 32'hDEAD_BEEF);
        chk("wr_rd_r2", q2[0], 32'h1234_5678);
        chk("wr_rd_d24", q1[2], 32'hDEAD_BEEF);
        tick();

        // Zero register.
        we = 1'b1; widx = 5'd0; din = 32'hFFFF_FFFF; r1 = 5'd0;
        tick();
        we = 1'b0;
        #2;
        chk("zero_reg_on",  q1[0], 32'd0);
        chk("zero_reg_off", q1[1], 32'hFFFF_FFFF);
        tick();

        // Same-cycle write/read collision.
        we = 1'b1; widx = 5'd5; din = 32'h0000_0005;
        tick();
        din = 32'hCAFE_0001; r1 = 5'd5;
`ifdef REGFILE_BYPASS_EN
        coll_exp = 32'hCAFE_0001;
`else
        coll_exp = 32'h0000_0005;
`endif
        #2;
        chk("collide_same", q1[0], coll_exp);
        tick();
        we = 1'b0;
        #2;
        chk("collide_next", q1[0], 32'hCAFE_0001);
        tick();

        // Clear wins over a simultaneous write; writes during the sweep are ignored.
        clr = 1'b1; we = 1'b1; widx = 5'd3; din = 32'hAAAA_AAAA; r1 = 5'd4; r2 = 5'd4;
        tick();
        clr = 1'b0; widx = 5'd7; din = 32'h0000_0077;
        #2;
        chk("clr_busy", {31'd0, bsy[0]}, 32'd1);
        fall = '{0, 0, 0};
        for (int n = 1; n <= 40; n++) begin
            if (n == 11) we = 1'b0;
            tick();
            for (int k = 0; k < 3; k++) if (fall[k] == 0 && bsy[k] == 1'b0) fall[k] = n;
        end
        chk("clr_fall_d32", fall[0], 32'd32);
        chk("clr_fall_d24", fall[2], 32'd24);
        r1 = 5'd3; r2 = 5'd7;
        #2;
        chk("clr_entry3", q1[0], 32'd0);
        chk("clr_entry7", q2[0], 32'd0);
        chk("clr_entry3_d24", q1[2], 32'd0);
        tick();
        r1 = 5'd1;
        #2;
        chk("clr_entry1", q1[0], 32'd0);
        tick();

        // Out-of-range write on the 24-entry build is dropped and reads 0.
        we = 1'b1; widx = 5'd30; din = 32'h3030_3030; r1 = 5'd30;
        tick();
        we = 1'b0;
        #2;
        chk("oor_read_d24", q1[2], 32'd0);
        chk("oor_read_d32", q1[0], 32'h3030_3030);
        tick();
        for (int i = 0; i < 24; i++) begin
            r1 = 5'(i); r2 = 5'(i);
            #2;
            chk("oor_no_alias", q1[2], 32'd0);
            tick();
        end

        // Reset in the middle of a sweep restarts it from entry 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fall = '{0, 0, 0};
        for (int n = 1; n <= 40; n++) begin
            tick();
            for (int k = 0; k < 3; k++) if (fall[k] == 0 && bsy[k] == 1'b0) fall[k] = n;
        end
        chk("mid_rst_d32", fall[0], 32'd32);
        chk("mid_rst_d24", fall[2], 32'd24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
